// File: rtl/iq_demod_pkg.sv
// Types and default widths shared by the I/Q demodulator datapath blocks.
package iq_demod_pkg;

    function automatic int acc_width(input int dw, input int osr);
        return 2 * dw + $clog2(osr);
    endfunction

    localparam int DEF_DW           = 5;
    localparam int DEF_OSR          = 4;
    localparam int DEF_PAIR_TIMEOUT = 3;
    localparam int ACC_W            = acc_width(DEF_DW, DEF_OSR);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_I = 3'd1,
        WAIT_Q = 3'd2,
        MUL1   = 3'd3,
        MUL2   = 3'd4
    } disc_state_t;

endpackage

// File: rtl/diff_phase_disc_chip_integrator.sv
// Sums OSR discriminator values per chip window and slices the sum into a hard chip.
module chip_integrator
    import iq_demod_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int OSR = DEF_OSR,
    parameter int AW  = ACC_W
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic signed [2*DW-1:0] disc_in,
    input  logic                   disc_valid,
    input  logic                   align,
    output logic                   chip_out,
    output logic                   chip_valid
);
    localparam int CW = $clog2(OSR);

    logic signed [AW-1:0] acc_q, acc_d, sum_s, disc_ext_s;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 chip_out_q, chip_out_d;
    logic                 chip_valid_q, chip_valid_d;

    // Window accumulation, align restart and end-of-window slicing.
    always_comb begin
        disc_ext_s   = AW'(disc_in);
        sum_s        = acc_q + disc_ext_s;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        chip_out_d   = chip_out_q;
        chip_valid_d = 1'b0;
        if (align) begin
            // A sample arriving with align opens the new window instead of being lost.
            if (disc_valid) begin
                acc_d = disc_ext_s;
                cnt_d = CW'(1);
            end else begin
                acc_d = '0;
                cnt_d = '0;
            end
        end else if (disc_valid) begin
            if (cnt_q == CW'(OSR - 1)) begin
                chip_out_d   = ~sum_s[AW-1];
                chip_valid_d = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
            end else begin
                acc_d = sum_s;
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            chip_out_q   <= 1'b0;
            chip_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            chip_out_q   <= chip_out_d;
            chip_valid_q <= chip_valid_d;
        end
    end

    assign chip_out   = chip_out_q;
    assign chip_valid = chip_valid_q;

endmodule

// File: rtl/diff_phase_disc.sv
// Pairs filtered I/Q samples, forms Q[n]*I[n-1] - I[n]*Q[n-1] on one shared multiplier
// over two cycles, and hands each discriminator value to the chip integrator.
module diff_phase_disc
    import iq_demod_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int OSR          = DEF_OSR,
    parameter int PAIR_TIMEOUT = DEF_PAIR_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic signed [DW-1:0]   i_in,
    input  logic                   i_valid,
    input  logic signed [DW-1:0]   q_in,
    input  logic                   q_valid,
    input  logic                   align,
    output logic signed [2*DW-1:0] disc_out,
    output logic                   disc_valid,
    output logic                   chip_out,
    output logic                   chip_valid,
    output logic                   pair_err
);
    localparam int PW = 2 * DW;
    localparam int TW = $clog2(PAIR_TIMEOUT + 1);

    disc_state_t          state_q, state_d;
    logic signed [DW-1:0] i_cur_q, i_cur_d, q_cur_q, q_cur_d;
    logic signed [DW-1:0] i_prev_q, i_prev_d, q_prev_q, q_prev_d;
    logic signed [DW-1:0] mul_a_s, mul_b_s;
    logic signed [PW-1:0] prod_s, p1_q, p1_d, disc_q, disc_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 primed_q, primed_d;
    logic                 disc_valid_q, disc_valid_d;
    logic                 pair_err_q, pair_err_d;
    logic                 strobe_s;

    // Shared multiplier: MUL1 forms q_cur*i_prev, every other state i_cur*q_prev.
    always_comb begin
        if (state_q == MUL1) begin
            mul_a_s = q_cur_q;
            mul_b_s = i_prev_q;
        end else begin
            mul_a_s = i_cur_q;
            mul_b_s = q_prev_q;
        end
        prod_s   = PW'(mul_a_s) * PW'(mul_b_s);
        strobe_s = i_valid | q_valid;
    end

    // Pairing FSM and discriminator datapath next-state.
    always_comb begin
        state_d      = state_q;
        i_cur_d      = i_cur_q;
        q_cur_d      = q_cur_q;
        i_prev_d     = i_prev_q;
        q_prev_d     = q_prev_q;
        p1_d         = p1_q;
        disc_d       = disc_q;
        tmo_d        = tmo_q;
        primed_d     = primed_q;
        disc_valid_d = 1'b0;
        pair_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (i_valid && q_valid) begin
                    i_cur_d = i_in;
                    q_cur_d = q_in;
                    state_d = MUL1;
                end else if (i_valid) begin
                    i_cur_d = i_in;
                    state_d = WAIT_Q;
                end else if (q_valid) begin
                    q_cur_d = q_in;
                    state_d = WAIT_I;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_Q: begin
                // With both strobes present the newest I pairs with the arriving Q.
                if (q_valid) begin
                    q_cur_d = q_in;
                    i_cur_d = i_valid ? i_in : i_cur_q;
                    state_d = MUL1;
                end else if (i_valid) begin
                    i_cur_d = i_in;
                    tmo_d   = '0;
                end else if (tmo_q == TW'(PAIR_TIMEOUT - 1)) begin
                    pair_err_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_I: begin
                if (i_valid) begin
                    i_cur_d = i_in;
                    q_cur_d = q_valid ? q_in : q_cur_q;
                    state_d = MUL1;
                end else if (q_valid) begin
                    q_cur_d = q_in;
                    tmo_d   = '0;
                end else if (tmo_q == TW'(PAIR_TIMEOUT - 1)) begin
                    pair_err_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            MUL1: begin
                p1_d       = prod_s;
                pair_err_d = strobe_s;
                state_d    = MUL2;
            end
            MUL2: begin
                pair_err_d = strobe_s;
                i_prev_d   = i_cur_q;
                q_prev_d   = q_cur_q;
                primed_d   = 1'b1;
                // The first pair after reset only seeds the previous sample.
                if (primed_q) begin
                    disc_d       = p1_q - prod_s;
                    disc_valid_d = 1'b1;
                end else begin
                    disc_d = disc_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pairing FSM, datapath and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            i_cur_q      <= '0;
            q_cur_q      <= '0;
            i_prev_q     <= '0;
            q_prev_q     <= '0;
            p1_q         <= '0;
            disc_q       <= '0;
            tmo_q        <= '0;
            primed_q     <= 1'b0;
            disc_valid_q <= 1'b0;
            pair_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_cur_q      <= i_cur_d;
            q_cur_q      <= q_cur_d;
            i_prev_q     <= i_prev_d;
            q_prev_q     <= q_prev_d;
            p1_q         <= p1_d;
            disc_q       <= disc_d;
            tmo_q        <= tmo_d;
            primed_q     <= primed_d;
            disc_valid_q <= disc_valid_d;
            pair_err_q   <= pair_err_d;
        end
    end

    assign disc_out   = disc_q;
    assign disc_valid = disc_valid_q;
    assign pair_err   = pair_err_q;

    chip_integrator #(
        .DW  (DW),
        .OSR (OSR),
        .AW  (acc_width(DW, OSR))
    ) u_chip_integrator (
        .clk        (clk),
        .resetn     (resetn),
        .disc_in    (disc_q),
        .disc_valid (disc_valid_q),
        .align      (align),
        .chip_out   (chip_out),
        .chip_valid (chip_valid)
    );

endmodule

// File: tb/tb_diff_phase_disc.sv
// Self-checking bench for diff_phase_disc: directed vector table, corner sequences,
// and randomized stimulus against an event-level reference model.
module tb_diff_phase_disc;
    localparam int DW  = 5;
    localparam int OSR = 4;
    localparam int PT  = 3;
    localparam int NR  = 1500;

    logic                   clk;
    logic                   resetn;
    logic signed [DW-1:0]   i_in, q_in;
    logic                   i_valid, q_valid, align;
    logic signed [2*DW-1:0] disc_out;
    logic                   disc_valid, chip_out, chip_valid, pair_err;

    diff_phase_disc #(.DW(DW), .OSR(OSR), .PAIR_TIMEOUT(PT)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_in       (i_in),
        .i_valid    (i_valid),
        .q_in       (q_in),
        .q_valid    (q_valid),
        .align      (align),
        .disc_out   (disc_out),
        .disc_valid (disc_valid),
        .chip_out   (chip_out),
        .chip_valid (chip_valid),
        .pair_err   (pair_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pi;
        int pq;
        int ci;
        int cq;
        int want;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int dv_cnt, dv_cyc, last_disc, err_cnt, err_cyc, cv_cnt, cv_cyc, last_chip;

    int e_dv   [NR+8];
    int e_disc [NR+8];
    int e_err  [NR+8];
    int e_cv   [NR+8];
    int e_chip [NR+8];

    task automatic check(input string name, input int act, input int want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (disc_valid) begin dv_cnt++; dv_cyc = cyc; last_disc = int'(disc_out); end
        if (pair_err) begin err_cnt++; err_cyc = cyc; end
        if (chip_valid) begin cv_cnt++; cv_cyc = cyc; last_chip = int'(chip_out); end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_mon();
        dv_cnt = 0; dv_cyc = 0; last_disc = 0; err_cnt = 0; err_cyc = 0;
        cv_cnt = 0; cv_cyc = 0; last_chip = 0;
    endtask

    task automatic do_reset();
        i_valid = 1'b0; q_valid = 1'b0; align = 1'b0;
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
    endtask

    // Simultaneous I/Q strobe, then two quiet cycles so the next pair lands on IDLE.
    task automatic send_pair(input int i, input int q, input bit al);
        i_in = DW'(i); q_in = DW'(q);
        i_valid = 1'b1; q_valid = 1'b1; align = al;
        step();
        i_valid = 1'b0; q_valid = 1'b0; align = 1'b0;
        idle(2);
    endtask

    task automatic random_phase();
        int pend, h_i, h_q, since, busy_end, p_i, p_q, primed, wsum, wcnt;
        int iv_val, qv_val, ci, cq;
        bit iv, qv, al, done;
        pend = 0; h_i = 0; h_q = 0; since = 0; busy_end = 0;
        p_i = 0; p_q = 0; primed = 0; wsum = 0; wcnt = 0;
        for (int k = 0; k < NR + 8; k++) begin
            e_dv[k] = 0; e_disc[k] = 0; e_err[k] = 0; e_cv[k] = 0; e_chip[k] = 0;
        end
        do_reset();
        for (int n = 0; n < NR; n++) begin
            iv = ($urandom_range(0, 99) < 40);
            qv = ($urandom_range(0, 99) < 40);
            al = ($urandom_range(0, 99) < 3);
            iv_val = int'($urandom_range(0, 31)) - 16;
            qv_val = int'($urandom_range(0, 31)) - 16;
            i_valid = iv; q_valid = qv; align = al;
            i_in = DW'(iv_val); q_in = DW'(qv_val);
            // Pairing: a completed pair keeps the multiplier busy for two cycles.
            done = 1'b0; ci = 0; cq = 0;
            if (n < busy_end) begin
                if (iv || qv) e_err[n+1] = 1;
            end else if (pend == 0) begin
                if (iv && qv) begin done = 1'b1; ci = iv_val; cq = qv_val; end
                else if (iv) begin pend = 1; h_i = iv_val; since = n; end
                else if (qv) begin pend = 2; h_q = qv_val; since = n; end
            end else if (pend == 1) begin
                if (qv) begin done = 1'b1; ci = iv ? iv_val : h_i; cq = qv_val; pend = 0; end
                else if (iv) begin h_i = iv_val; since = n; end
                else if (n - since == PT) begin e_err[n+1] = 1; pend = 0; end
            end else begin
                if (iv) begin done = 1'b1; cq = qv ? qv_val : h_q; ci = iv_val; pend = 0; end
                else if (qv) begin h_q = qv_val; since = n; end
                else if (n - since == PT) begin e_err[n+1] = 1; pend = 0; end
            end
            if (done) begin
                busy_end = n + 3;
                if (primed != 0) begin
                    e_dv[n+3]   = 1;
                    e_disc[n+3] = cq * p_i - ci * p_q;
                end
                p_i = ci; p_q = cq; primed = 1;
            end
            // Chip window: align restarts it, keeping a coincident discriminator value.
            if (al) begin
                if (e_dv[n] != 0) begin wsum = e_disc[n]; wcnt = 1; end
                else begin wsum = 0; wcnt = 0; end
            end else if (e_dv[n] != 0) begin
                wsum += e_disc[n];
                wcnt++;
                if (wcnt == OSR) begin
                    e_cv[n+1] = 1; e_chip[n+1] = (wsum >= 0) ? 1 : 0;
                    wsum = 0; wcnt = 0;
                end
            end
            step();
            check($sformatf("rnd_dv@%0d", n+1), int'(disc_valid), e_dv[n+1]);
            check($sformatf("rnd_err@%0d", n+1), int'(pair_err), e_err[n+1]);
            check($sformatf("rnd_cv@%0d", n+1), int'(chip_valid), e_cv[n+1]);
            if (e_dv[n+1] != 0) check($sformatf("rnd_disc@%0d", n+1), int'(disc_out), e_disc[n+1]);
            if (e_cv[n+1] != 0) check($sformatf("rnd_chip@%0d", n+1), int'(chip_out), e_chip[n+1]);
        end
        i_valid = 1'b0; q_valid = 1'b0; align = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        int t;
        vecs[0] = '{pi:  4, pq:   0, ci:   0, cq:   4, want:  16};
        vecs[1] = '{pi:  0, pq:   4, ci:   4, cq:   0, want: -16};
        vecs[2] = '{pi: -16, pq: -16, ci: 15, cq: -16, want: 496};
        vecs[3] = '{pi: -16, pq: 15, ci: -16, cq: -16, want: 496};
        vecs[4] = '{pi:  3, pq:  -2, ci:  -5, cq:   7, want:  11};
        vecs[5] = '{pi: -16, pq: -16, ci: -16, cq: -16, want: 0};

        i_in = '0; q_in = '0; i_valid = 1'b0; q_valid = 1'b0; align = 1'b0;
        resetn = 1'b0;
        do_reset();
        check("reset_disc_out", int'(disc_out), 0);
        check("reset_strobes", int'({disc_valid, chip_valid, pair_err}), 0);
        check("reset_chip_out", int'(chip_out), 0);

        for (int k = 0; k < 6; k++) begin
            do_reset();
            clear_mon();
            send_pair(vecs[k].pi, vecs[k].pq, 1'b0);
            t = cyc;
            send_pair(vecs[k].ci, vecs[k].cq, 1'b0);
            idle(4);
            check($sformatf("tbl%0d_count", k), dv_cnt, 1);
            check($sformatf("tbl%0d_latency", k), dv_cyc - t, 3);
            check($sformatf("tbl%0d_disc", k), last_disc, vecs[k].want);
        end

        // Skewed pairing: I at t, Q at t+2.
        do_reset();
        clear_mon();
        send_pair(1, 1, 1'b0);
        t = cyc;
        i_in = DW'(2); i_valid = 1'b1; step(); i_valid = 1'b0; step();
        q_in = DW'(3); q_valid = 1'b1; step(); q_valid = 1'b0;
        idle(5);
        check("skew_count", dv_cnt, 1);
        check("skew_latency", dv_cyc - t, 5);
        check("skew_disc", last_disc, 1);
        check("skew_err", err_cnt, 0);

        // Lone I sample times out and is discarded.
        clear_mon();
        t = cyc;
        i_in = DW'(5); i_valid = 1'b1; step(); i_valid = 1'b0;
        idle(6);
        check("tmo_err", err_cnt, 1);
        check("tmo_err_cycle", err_cyc - t, PT + 1);
        check("tmo_dv", dv_cnt, 0);
        send_pair(1, -1, 1'b0);
        check("tmo_next_disc", last_disc, -5);

        // Overrun: fresh strobes during MUL2 are dropped.
        clear_mon();
        i_in = DW'(4); q_in = DW'(4); i_valid = 1'b1; q_valid = 1'b1; step();
        i_valid = 1'b0; q_valid = 1'b0; step();
        i_in = DW'(-7); q_in = DW'(6); i_valid = 1'b1; q_valid = 1'b1; step();
        i_valid = 1'b0; q_valid = 1'b0;
        idle(6);
        check("ovr_err", err_cnt, 1);
        check("ovr_dv", dv_cnt, 1);
        check("ovr_disc", last_disc, 8);
        send_pair(2, 1, 1'b0);
        check("ovr_next_disc", last_disc, -4);

        // Chip window: +16, +16, -16, -8 sums to +8.
        do_reset();
        clear_mon();
        send_pair(4, 0, 1'b0);
        send_pair(0, 4, 1'b0);
        send_pair(-4, 0, 1'b0);
        send_pair(-4, 4, 1'b0);
        send_pair(2, 0, 1'b0);
        idle(2);
        check("chip_dv_count", dv_cnt, 4);
        check("chip_count", cv_cnt, 1);
        check("chip_value", last_chip, 1);
        check("chip_latency", cv_cyc - dv_cyc, 1);
        check("disc_hold", int'(disc_out), -8);

        // Reset while the multiplier is in MUL1, then re-prime.
        i_in = DW'(1); q_in = DW'(1); i_valid = 1'b1; q_valid = 1'b1; step();
        i_valid = 1'b0; q_valid = 1'b0;
        resetn = 1'b0;
        step();
        check("midrst_disc_out", int'(disc_out), 0);
        check("midrst_chip_out", int'(chip_out), 0);
        check("midrst_strobes", int'({disc_valid, chip_valid, pair_err}), 0);
        resetn = 1'b1;
        clear_mon();
        send_pair(3, 3, 1'b0);
        idle(3);
        check("midrst_prime", dv_cnt, 0);
        send_pair(3, -3, 1'b0);
        check("midrst_after_disc", last_disc, -18);

        // Align on the second disc_valid restarts the window: 16-16-8+6 = -2.
        do_reset();
        clear_mon();
        send_pair(4, 0, 1'b0);
        send_pair(0, 4, 1'b0);
        send_pair(-4, 0, 1'b0);
        send_pair(-4, 4, 1'b1);
        send_pair(2, 0, 1'b0);
        send_pair(0, 3, 1'b0);
        idle(2);
        check("align_dv_count", dv_cnt, 5);
        check("align_chip_count", cv_cnt, 1);
        check("align_chip_value", last_chip, 0);
        check("align_chip_latency", cv_cyc - dv_cyc, 1);

        random_phase();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/diff_phase_disc.md
Name: diff_phase_disc

Overview:
Differential phase discriminator and chip slicer sitting directly downstream of the two filter_20 instances (I and Q paths) in iq_demod. It pairs the filtered I/Q samples and computes the cross-product discriminator Q[n]·I[n-1] − I[n]·Q[n-1] with a single shared multiplier over two cycles. It integrates OSR consecutive discriminator values and emits one hard chip decision per window for the downstream chip/symbol correlator.

Parameters:
DW, 5, filtered I/Q sample width (signed), matches filter_20 data_out
OSR, 4, discriminator samples integrated per chip (≥2)
PAIR_TIMEOUT, 3, max cycles to wait for the second of an I/Q pair before discarding

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
i_in  in  DW  filtered I sample, signed
i_valid  in  1  one-cycle strobe qualifying i_in (filter_20 out_valid)
q_in  in  DW  filtered Q sample, signed
q_valid  in  1  one-cycle strobe qualifying q_in
align  in  1  one-cycle pulse from symbol sync: restart chip window
disc_out  out  2*DW  discriminator value, signed
disc_valid  out  1  one-cycle strobe qualifying disc_out
chip_out  out  1  hard chip decision (1 = integrated sum ≥ 0)
chip_valid  out  1  one-cycle strobe qualifying chip_out
pair_err  out  1  one-cycle pulse: pairing timeout or overrun, sample dropped

Behaviour:
- Clock/reset: one clock, clk; asynchronous active-low reset, resetn. All registers, including prev I/Q and primed flag, clear to 0; FSM → IDLE.
- Reset values: disc_out=0, disc_valid=0, chip_out=0, chip_valid=0, pair_err=0.
- FSM states: IDLE, WAIT_I, WAIT_Q, MUL1, MUL2.
  - IDLE: i_valid&q_valid → capture both, → MUL1. i_valid only → capture I, → WAIT_Q. q_valid only → capture Q, → WAIT_I.
  - WAIT_Q/WAIT_I: missing strobe arrives → capture, → MUL1. Timeout counter reaches PAIR_TIMEOUT with no strobe → pair_err pulse, discard held sample, → IDLE. If the already-held component strobes again instead, overwrite it and restart the timeout count.
  - MUL1: p1 = q_cur·i_prev registered. Any i_valid/q_valid during MUL1 or MUL2 → pair_err pulse; the sample is dropped (overrun).
  - MUL2: p2 = i_cur·q_prev. Then disc = p1 − p2, registered into disc_out with disc_valid, and i_prev/q_prev ← i_cur/q_cur. → IDLE.
- Latency: pair complete on cycle t → disc_valid on cycle t+3. Sustains one pair every 3 cycles; filter_20 delivers one every 5.
- Priming: the first pair after reset only loads i_prev/q_prev. disc_valid stays 0 and the window is unaffected.
- Arithmetic: product is signed 2*DW; disc range −496..+496 at DW=5, fits signed 2*DW with no saturation. Full signed multiply; no truncation.
- Chip integrator:
  - acc is signed 2*DW+clog2(OSR), with a window count 0..OSR−1.
  - On each disc_valid: acc += disc_out, count++.
  - When count reaches OSR: chip_out = (acc ≥ 0), chip_valid pulses on the following cycle, then acc and count clear.
- align: clears acc and count. If align coincides with disc_valid, acc is seeded with that disc and count = 1 (align wins, sample kept). align does not affect the discriminator FSM.
- chip_out holds its value between chip_valid strobes. disc_out holds its last value.

Decomposition:
- Package iq_demod_pkg holds:
  - the state enum type disc_state_t (IDLE, WAIT_I, WAIT_Q, MUL1, MUL2)
  - localparam ACC_W = 2*DW+$clog2(OSR)
  - the default DW/OSR constants shared with filter_20 wrappers.
- One sub-module, chip_integrator: disc_valid/disc_out/align in, chip_out/chip_valid out. The top holds the pairing FSM and the shared multiplier.

Test Plan:
- Reset mid-stream: assert resetn=0 while in MUL1 → all outputs 0 next cycle; after release, the first pair produces no disc_valid (priming).
- Rotation: pairs (I,Q)=(4,0) then (0,4), simultaneous strobes → disc_out=+16, disc_valid exactly 3 cycles after the second pair; reversed order gives −16.
- Extremes: prev (−16,−16), current (15,−16) → disc_out=+496. prev (−16,15), current (−16,−16) → −16·−16 − (−16·15) = 256+240 = +496.
- Skewed pairing: i_valid at t, q_valid at t+2 → disc_valid at t+5. i_valid only with no q_valid for PAIR_TIMEOUT cycles → pair_err=1 once, no disc_valid.
- Overrun: new simultaneous strobes during MUL2 → pair_err pulse, exactly one disc_valid for the accepted pair.
- Chip window: OSR=4, discs +16,+16,−16,−8 → chip_out=1 (sum +8), chip_valid one cycle after the 4th disc_valid. Assert align on the 2nd disc_valid → window restarts and chip_valid follows the 5th disc_valid.
